// File: rtl/life_array_ctrl.sv
// life_array_ctrl -- sequencer between the host side and a ROWS x COLS life
// cell array. Runs one command at a time:
//   LOAD : streams ROWS row beats into the array (one-hot row strobe + data)
//   RUN  : asserts arr_run for N consecutive cycles (N generations)
//   READ : parallel-loads the column shift chains, then drains ROWS rows
// Ports:
//   clk, reset             clock, synchronous active-low reset
//   cmd_*                  command handshake (accepted only in IDLE)
//   in_*                   LOAD row stream (valid/ready)
//   out_*                  READ row stream (valid/ready), pass-through of chain
//   arr_*                  strobes/data to the cell array, chain tail input
//   busy, done, gen_total  status: not idle, completion pulse, generation count
module life_array_ctrl #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [GEN_W-1:0] cmd_gens,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [COLS-1:0]  in_row,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [COLS-1:0]  out_row,
  output logic             arr_run,
  output logic [ROWS-1:0]  arr_load_in,
  output logic [COLS-1:0]  arr_in_data,
  output logic             arr_load_out,
  output logic             arr_shift,
  input  logic [COLS-1:0]  arr_chain_out,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_total
);

  // Row counter must reach ROWS: LOAD parks there for the last strobe cycle.
  localparam int RW = $clog2(ROWS + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_RUN  = 2'd2;
  localparam logic [1:0] OP_READ = 2'd3;

  localparam logic [ROWS-1:0] ROW0_ONEHOT = {{(ROWS-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [GEN_W-1:0] cnt_q, cnt_d;
  logic [GEN_W-1:0] gen_total_q, gen_total_d;
  logic [ROWS-1:0]  load_in_q, load_in_d;
  logic [COLS-1:0]  in_data_q, in_data_d;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    gen_total_d = gen_total_q;
    load_in_d   = '0;
    in_data_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              state_d = ST_LOAD;
              row_d   = '0;
            end
            OP_RUN: begin
              cnt_d   = cmd_gens;
              state_d = (cmd_gens == '0) ? ST_DONE : ST_RUN;
            end
            OP_READ: state_d = ST_CAPTURE;
            default: state_d = ST_DONE;
          endcase
        end
      end
      ST_LOAD: begin
        // row_q == ROWS is the cycle the final strobe is on the array;
        // done follows it rather than coinciding with it.
        if (row_q == RW'(ROWS)) begin
          state_d = ST_DONE;
        end else if (in_valid) begin
          load_in_d = ROW0_ONEHOT << row_q;
          in_data_d = in_row;
          row_d     = row_q + RW'(1);
        end
      end
      ST_RUN: begin
        // Down-counter exits on 1, so a full 2^GEN_W-1 count never wraps.
        gen_total_d = gen_total_q + GEN_W'(1);
        cnt_d       = cnt_q - GEN_W'(1);
        if (cnt_q == GEN_W'(1)) state_d = ST_DONE;
      end
      ST_CAPTURE: begin
        row_d   = '0;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_ready) begin
          row_d = row_q + RW'(1);
          if (row_q == RW'(ROWS - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      cnt_q       <= '0;
      gen_total_q <= '0;
      load_in_q   <= '0;
      in_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      gen_total_q <= gen_total_d;
      load_in_q   <= load_in_d;
      in_data_q   <= in_data_d;
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign in_ready     = (state_q == ST_LOAD) && (row_q != RW'(ROWS));
  assign out_valid    = (state_q == ST_DRAIN);
  assign out_row      = out_valid ? arr_chain_out : '0;
  assign arr_shift    = out_valid && out_ready;
  assign arr_run      = (state_q == ST_RUN);
  assign arr_load_out = (state_q == ST_CAPTURE);
  assign arr_load_in  = load_in_q;
  assign arr_in_data  = in_data_q;
  assign gen_total    = gen_total_q;

endmodule

// File: tb/tb_life_array_ctrl.sv
// Testbench for life_array_ctrl: models the cell array (life rule, dead
// border, column shift chains) around the controller and checks handshakes,
// strobe timing and drained rows against a generation-level model.
module tb_life_array_ctrl;
  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int GEN_W = 16;

  typedef logic [ROWS-1:0][COLS-1:0] grid_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [GEN_W-1:0] cmd_gens = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [COLS-1:0]  in_row = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [COLS-1:0]  out_row;
  logic             arr_run;
  logic [ROWS-1:0]  arr_load_in;
  logic [COLS-1:0]  arr_in_data;
  logic             arr_load_out;
  logic             arr_shift;
  logic [COLS-1:0]  arr_chain_out;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] gen_total;

  always #5 clk = ~clk;

  life_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_gens(cmd_gens),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .arr_run(arr_run), .arr_load_in(arr_load_in), .arr_in_data(arr_in_data),
    .arr_load_out(arr_load_out), .arr_shift(arr_shift), .arr_chain_out(arr_chain_out),
    .busy(busy), .done(done), .gen_total(gen_total)
  );

  function automatic grid_t life_step(input grid_t g);
    grid_t n;
    int cnt, rr, cc;
    n = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
              if (g[rr][cc]) cnt++;
          end
        end
        n[r][c] = g[r][c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
    return n;
  endfunction

  // Cell array stand-in driven only by the controller's strobes.
  grid_t env_grid, env_chain;
  always @(posedge clk) begin
    if (arr_run) env_grid <= life_step(env_grid);
    else
      for (int r = 0; r < ROWS; r++)
        if (arr_load_in[r]) env_grid[r] <= arr_in_data;
    if (arr_load_out) env_chain <= env_grid;
    else if (arr_shift) begin
      for (int r = 0; r < ROWS - 1; r++) env_chain[r] <= env_chain[r+1];
      env_chain[ROWS-1] <= '0;
    end
  end
  assign arr_chain_out = env_chain[0];

  int cyc = 0, run_cnt = 0, done_cnt = 0, excl_cnt = 0, act_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (arr_run) run_cnt <= run_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if ((int'(arr_run) + int'(|arr_load_in) + int'(arr_load_out)) > 1) excl_cnt <= excl_cnt + 1;
    if (arr_run || arr_load_in != '0 || arr_load_out || arr_shift || arr_in_data != '0)
      act_cnt <= act_cnt + 1;
  end

  int n_chk = 0, n_pass = 0;
  grid_t mdl_grid;
  logic [GEN_W-1:0] mdl_gen;

  task automatic send_cmd(input logic [1:0] op, input logic [GEN_W-1:0] g, input string nm);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_gens = g;
    #1;
    n_chk++;
    if (cmd_ready !== 1'b1) $display("FAIL %s_accept: cmd_ready=%b want 1", nm, cmd_ready);
    else n_pass++;
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_op = '0; cmd_gens = '0;
  endtask

  task automatic test_reset();
    int d0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if ({cmd_ready, busy, done, in_ready, out_valid, arr_run, arr_load_out, arr_shift, arr_load_in, arr_in_data, gen_total}
        !== {1'b1, 7'b0, {ROWS{1'b0}}, {COLS{1'b0}}, {GEN_W{1'b0}}})
      $display("FAIL reset_state: rdy=%b busy=%b done=%b run=%b li=%h gt=%h want idle zeros",
               cmd_ready, busy, done, arr_run, arr_load_in, gen_total);
    else n_pass++;
    reset = 1'b1;
    send_cmd(2'd2, GEN_W'(100), "reset_run");
    repeat (10) @(negedge clk);
    #1;
    n_chk++;
    if (arr_run !== 1'b1) $display("FAIL reset_midrun: arr_run=%b want 1", arr_run);
    else n_pass++;
    d0 = done_cnt;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_chk++;
    if ({arr_run, gen_total, busy, cmd_ready} !== {1'b0, {GEN_W{1'b0}}, 1'b0, 1'b1})
      $display("FAIL reset_abort: run=%b gt=%h busy=%b rdy=%b want 0 0 0 1", arr_run, gen_total, busy, cmd_ready);
    else n_pass++;
    n_chk++;
    if (done_cnt !== d0) $display("FAIL reset_nodone: done pulses=%0d want 0", done_cnt - d0);
    else n_pass++;
    mdl_gen = '0;
  endtask

  task automatic test_load(input grid_t pat, input bit rnd, input string nm);
    int beats, last_k, done_k, prow, d0;
    bit pend;
    logic [COLS-1:0] pdata;
    logic [ROWS-1:0] exp_li, one;
    one = {{(ROWS-1){1'b0}}, 1'b1};
    d0 = done_cnt;
    send_cmd(2'd1, '0, nm);
    beats = 0; pend = 0; last_k = -1; done_k = -1; prow = 0; pdata = '0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (beats < ROWS) begin
        in_valid = rnd ? ($urandom_range(0, 2) != 0) : (k % 2 == 1);
        in_row   = pat[beats];
      end else begin
        in_valid = 1'b0;
        in_row   = COLS'($urandom);
      end
      #1;
      exp_li = pend ? (one << prow) : '0;
      n_chk++;
      if (arr_load_in !== exp_li || arr_in_data !== (pend ? pdata : '0))
        $display("FAIL %s_strobe: li=%h data=%h want li=%h data=%h", nm, arr_load_in, arr_in_data,
                 exp_li, pend ? pdata : '0);
      else n_pass++;
      if (pend) last_k = k;
      if (done) begin done_k = k; break; end
      pend = in_valid && in_ready;
      if (pend) begin prow = beats; pdata = in_row; beats++; end
    end
    in_valid = 1'b0;
    n_chk++;
    if (beats != ROWS || done_k != last_k + 1)
      $display("FAIL %s_done: beats=%0d done_k=%0d want beats=%0d done_k=%0d", nm, beats, done_k, ROWS, last_k + 1);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if (done_cnt - d0 != 1) $display("FAIL %s_once: done pulses=%0d want 1", nm, done_cnt - d0);
    else n_pass++;
    mdl_grid = pat;
  endtask

  task automatic test_run(input logic [GEN_W-1:0] n, input string nm);
    int runs, done_k, budget;
    budget = int'(n) + 10;
    send_cmd(2'd2, n, nm);
    runs = 0; done_k = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      #1;
      if (arr_run) runs++;
      if (done) begin done_k = k; break; end
    end
    mdl_gen = mdl_gen + n;
    if (int'(n) <= 64) repeat (int'(n)) mdl_grid = life_step(mdl_grid);
    n_chk++;
    if (runs != int'(n) || done_k != int'(n) + 1)
      $display("FAIL %s_timing: runs=%0d done_k=%0d want runs=%0d done_k=%0d", nm, runs, done_k, n, int'(n) + 1);
    else n_pass++;
    n_chk++;
    if (gen_total !== mdl_gen) $display("FAIL %s_gen_total: got %h want %h", nm, gen_total, mdl_gen);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if ({busy, cmd_ready, done} !== 3'b010) $display("FAIL %s_idle: busy/rdy/done=%b want 010", nm, {busy, cmd_ready, done});
    else n_pass++;
  endtask

  task automatic test_read(input grid_t exp, input int stall_row, input int stall_len,
                           input bit rnd, input bit ignore, input string nm);
    int beat, stall_left, done_k, r0;
    bit stalled;
    logic [COLS-1:0] hold;
    r0 = run_cnt;
    send_cmd(2'd3, '0, nm);
    beat = 0; stall_left = stall_len; stalled = 0; done_k = -1; hold = '0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      cmd_valid = ignore && (beat < ROWS) && (k > 1);
      cmd_op = 2'd2; cmd_gens = GEN_W'(5);
      if (k == 1) out_ready = 1'b0;
      else if (beat == stall_row && stall_left > 0) begin out_ready = 1'b0; stall_left--; end
      else out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (k == 1) begin
        n_chk++;
        if ({arr_load_out, out_valid} !== 2'b10)
          $display("FAIL %s_capture: load_out=%b out_valid=%b want 1 0", nm, arr_load_out, out_valid);
        else n_pass++;
        continue;
      end
      if (done) begin done_k = k; break; end
      if (beat >= ROWS) break;
      n_chk++;
      if ({out_valid, out_row, arr_shift} !== {1'b1, exp[beat], out_ready})
        $display("FAIL %s_row%0d: valid=%b row=%h shift=%b want 1 %h %b", nm, beat, out_valid, out_row,
                 arr_shift, exp[beat], out_ready);
      else n_pass++;
      if (beat == stall_row && !out_ready) begin
        if (!stalled) begin hold = out_row; stalled = 1; end
        else begin
          n_chk++;
          if (out_row !== hold) $display("FAIL %s_stall_hold: row=%h want %h", nm, out_row, hold);
          else n_pass++;
        end
      end
      if (ignore) begin
        n_chk++;
        if (cmd_ready !== 1'b0) $display("FAIL %s_busy_rdy: cmd_ready=%b want 0", nm, cmd_ready);
        else n_pass++;
      end
      if (out_ready) beat++;
    end
    out_ready = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_gens = '0;
    n_chk++;
    if (done_k < 0 || beat != ROWS) $display("FAIL %s_done: beats=%0d done_k=%0d want %0d beats then done", nm, beat, done_k, ROWS);
    else n_pass++;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (run_cnt != r0 || busy !== 1'b0)
      $display("FAIL %s_ignored: run cycles=%0d busy=%b want 0 0", nm, run_cnt - r0, busy);
    else n_pass++;
  endtask

  task automatic test_nop();
    int a0, d0;
    a0 = act_cnt; d0 = done_cnt;
    send_cmd(2'd0, '0, "nop");
    @(negedge clk);
    #1;
    n_chk++;
    if ({done, busy} !== 2'b11) $display("FAIL nop_done: done/busy=%b want 11", {done, busy});
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if ({done, busy, cmd_ready} !== 3'b001 || act_cnt != a0 || done_cnt - d0 != 1)
      $display("FAIL nop_quiet: done/busy/rdy=%b arr activity=%0d pulses=%0d want 001 0 1",
               {done, busy, cmd_ready}, act_cnt - a0, done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_gen_wrap();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mdl_gen = '0;
    test_run(GEN_W'(2), "wrap_pre");
    test_run({GEN_W{1'b1}}, "wrap_full");
    n_chk++;
    if (gen_total !== GEN_W'(1)) $display("FAIL wrap_value: gen_total=%h want 0001", gen_total);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    grid_t pat;
    logic [GEN_W-1:0] g;
    for (int i = 0; i < 3; i++) begin
      pat = {$urandom, $urandom};
      g = GEN_W'($urandom_range(1, 12));
      test_load(pat, 1'b1, "rnd_load");
      test_run(g, "rnd_run");
      test_read(mdl_grid, $urandom_range(0, ROWS - 1), $urandom_range(0, 3), 1'b1, 1'b0, "rnd_read");
    end
  endtask

  initial begin
    grid_t glider, blinker, blinker_v;
    glider = '0;  glider[0] = 8'h02; glider[1] = 8'h04; glider[2] = 8'h07;
    blinker = '0; blinker[3] = 8'h1C;
    blinker_v = '0; blinker_v[2] = 8'h08; blinker_v[3] = 8'h08; blinker_v[4] = 8'h08;

    test_reset();
    test_load(glider, 1'b0, "load_glider");
    test_run(GEN_W'(4), "run4");
    test_run(GEN_W'(0), "run0");
    test_read(mdl_grid, -1, 0, 1'b0, 1'b0, "read_glider");
    test_load(blinker, 1'b1, "load_blinker");
    test_run(GEN_W'(1), "run1");
    test_read(blinker_v, 3, 5, 1'b0, 1'b1, "read_blinker");
    test_nop();
    test_back_to_back();
    test_gen_wrap();

    n_chk++;
    if (excl_cnt != 0) $display("FAIL exclusive: overlap cycles=%0d want 0", excl_cnt);
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
